// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter that lets NREQ producers share one synchronous FIFO write port,
// granting bursts of up to MAX_BURST beats; the data path is purely combinational.
module fifo_wr_arbiter #(
    parameter int NREQ      = 4,
    parameter int WIDTH     = 32,
    parameter int MAX_BURST = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ*WIDTH-1:0]     req_data,
    output logic [NREQ-1:0]           req_ready,
    input  logic                      fifo_wfull,
    output logic                      fifo_winc,
    output logic [WIDTH-1:0]          fifo_wdata,
    output logic [$clog2(NREQ)-1:0]   grant_id,
    output logic                      busy
);

    localparam int OW = $clog2(NREQ);
    localparam int CW = $clog2(MAX_BURST) + 1;

    typedef enum logic {IDLE, GRANT} state_t;

    state_t          state;
    logic [OW-1:0]   owner;
    logic [OW-1:0]   last_owner;
    logic [CW-1:0]   beat_cnt;
    logic            beat;
    logic            burst_done;
    logic            release_now;

    // First set bit after 'last', wrapping so that 'last' itself is tried at the very end.
    function automatic logic [OW-1:0] rr_pick(input logic [NREQ-1:0] v,
                                              input logic [OW-1:0]   last);
        logic [OW-1:0]   sel;
        logic [NREQ-1:0] sh;
        int              idx;
        sel = '0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = (int'(last) + k) % NREQ;
            sh  = v >> idx;
            if (sh[0]) sel = OW'(idx);
        end
        return sel;
    endfunction

    assign beat        = (state == GRANT) && req_valid[owner] && !fifo_wfull;
    assign burst_done  = beat && (int'(beat_cnt) + 1 == MAX_BURST);
    assign release_now = (state == GRANT) && (burst_done || !req_valid[owner]);

    assign fifo_winc  = beat;
    assign fifo_wdata = WIDTH'(req_data >> (int'(owner) * WIDTH));
    assign grant_id   = (state == GRANT) ? owner : '0;
    assign busy       = (state == GRANT);

    always_comb begin
        req_ready = '0;
        if (state == GRANT && !fifo_wfull) req_ready[owner] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            owner      <= '0;
            last_owner <= OW'(NREQ - 1);
            beat_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req_valid) begin
                        state    <= GRANT;
                        owner    <= rr_pick(req_valid, last_owner);
                        beat_cnt <= '0;
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        last_owner <= owner;
                        // Hand straight over when anyone is waiting, avoiding an idle bubble.
                        if (|req_valid) begin
                            owner    <= rr_pick(req_valid, owner);
                            beat_cnt <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (beat) begin
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of producers sharing one synchronous FIFO write port; legal range 2..8.
REQ-002 Parameter WIDTH, default 32: data word width.
REQ-003 Parameter MAX_BURST, default 4: maximum consecutive beats per grant; legal range 1..16.
REQ-004 clk  input  1  single clock; all state is updated on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 req_valid  input  NREQ  per-producer word-available flag.
REQ-007 req_data  input  NREQ*WIDTH  producer i data occupies bits [i*WIDTH +: WIDTH].
REQ-008 req_ready  output  NREQ  per-producer accept flag.
REQ-009 fifo_wfull  input  1  full flag from the shared FIFO.
REQ-010 fifo_winc  output  1  FIFO write strobe.
REQ-011 fifo_wdata  output  WIDTH  FIFO write data.
REQ-012 grant_id  output  clog2(NREQ)  index of the current owner; 0 when idle.
REQ-013 busy  output  1  high while state is GRANT.

Function
REQ-014 The block SHALL use a two-state FSM, IDLE and GRANT, plus registers owner, last_owner and beat_cnt (clog2(MAX_BURST)+1 bits).
REQ-015 In IDLE, if any req_valid bit is high at a clock edge, the block SHALL enter GRANT with owner set to the first set bit searched round-robin from last_owner+1 (mod NREQ), wrapping through last_owner; beat_cnt SHALL be cleared to 0.
REQ-016 In IDLE, req_ready SHALL be all zero and fifo_winc SHALL be 0, so the first word is accepted no earlier than one cycle after req_valid rises.
REQ-017 In GRANT, req_ready[owner] SHALL equal !fifo_wfull; all other req_ready bits SHALL be 0.
REQ-018 A beat SHALL occur when req_valid[owner] && req_ready[owner]; fifo_winc SHALL equal that beat condition combinationally, and fifo_wdata SHALL equal the owner's slice of req_data.
REQ-019 fifo_winc SHALL never be high while fifo_wfull is high.
REQ-020 On each beat, beat_cnt SHALL increment by 1.
REQ-021 Release SHALL occur at a clock edge in GRANT when either (a) a beat occurs and beat_cnt+1 == MAX_BURST, or (b) req_valid[owner] is low.
REQ-022 While fifo_wfull is high and req_valid[owner] is high, the grant SHALL be held and beat_cnt SHALL be unchanged.
REQ-023 On release, last_owner SHALL take the value of owner; if any req_valid bit is high in the same cycle, the block SHALL remain in GRANT with a new owner chosen per REQ-015 from the updated last_owner, with beat_cnt cleared; otherwise it SHALL go to IDLE.
REQ-024 In the release search of REQ-023, the releasing owner SHALL be selectable only if no other req_valid bit is set.
REQ-025 grant_id SHALL equal owner in GRANT and 0 in IDLE; busy SHALL be 1 exactly when the state is GRANT.
REQ-026 Producers SHALL hold req_valid and req_data stable until accepted; the block does not buffer data and has no storage on the data path.

Reset
REQ-027 An asserted rst_n SHALL force state=IDLE, owner=0, last_owner=NREQ-1 (so producer 0 wins first), and beat_cnt=0 immediately, without waiting for a clock edge.
REQ-028 During reset, req_ready=0, fifo_winc=0, grant_id=0 and busy=0; fifo_wdata is don't-care.
REQ-029 Reset asserted mid-burst SHALL drop fifo_winc within the same cycle; no partial write SHALL occur on the following edge.
REQ-030 After deassertion, the first grant SHALL follow REQ-015 from the reset value of last_owner.

Verification
REQ-031 Reset release, all req_valid=4'b1111, fifo_wfull=0, MAX_BURST=4 -> producers 0,1,2,3 each write 4 beats in order; no idle cycle between bursts; 16 writes in 17 cycles.
REQ-032 Only producer 2 is valid for 3 words, then it deasserts -> 3 writes with grant_id=2, then release and IDLE; the next grant searches from 3.
REQ-033 fifo_wfull raised for 5 cycles after beat 2 of producer 1's burst -> fifo_winc=0 and req_ready=0 for those 5 cycles; grant_id stays 1; the burst resumes and ends after beat 4.
REQ-034 Producer 3 owner, last_owner wrap, only producers 0 and 3 valid -> after producer 3's burst, owner becomes 0 (wrap-around), not 3.
REQ-035 rst_n pulsed low during beat 3 of a burst -> fifo_winc falls immediately; after release, producer 0 is granted first.
REQ-036 Random valid/full stimulus for 10k cycles -> FIFO write order and count match a reference round-robin model; fifo_winc is never high with fifo_wfull high; no producer waits longer than (NREQ-1)*MAX_BURST beats once valid.
